// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MEM stage and its MEM/WB pipeline register.
//   - mem_state_e : MEM stage access FSM states
//   - MEM_READ_BIT / MEM_WRITE_BIT : bit positions inside the 2-bit M control
//   - DATA_W_DEF / REG_ADDR_W_DEF  : default datapath / register-index widths
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam int MEM_READ_BIT  = 1;
    localparam int MEM_WRITE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// ----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register. Loads the writeback triple every cycle, or a
// bubble (all zero) while the MEM stage is stalled so that a held EX/MEM
// instruction is never written back twice.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_bubble         : 1 = load a bubble instead of the data inputs
//   i_result         : writeback value
//   i_rd_addr        : destination register
//   i_reg_write      : writeback enable
//   o_result, o_rd_addr, o_reg_write : registered outputs toward WB
// ----------------------------------------------------------------------------
module mem_wb_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_bubble,
    input  logic [DATA_W-1:0]     i_result,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_reg_write,
    output logic [DATA_W-1:0]     o_result,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic                  o_reg_write
);

    logic [DATA_W-1:0]     r_result;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_reg_write;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result    <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
        end else if (i_bubble) begin
            r_result    <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
        end else begin
            r_result    <= i_result;
            r_rd_addr   <= i_rd_addr;
            r_reg_write <= i_reg_write;
        end
    end

    assign o_result    = r_result;
    assign o_rd_addr   = r_rd_addr;
    assign o_reg_write = r_reg_write;

endmodule

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
// MEM stage plus MEM/WB register. Non-memory ops pass straight into MEM/WB
// with one cycle latency. Loads/stores go through a registered req/ready
// data-memory port; the stage stalls upstream until the access completes or
// times out, then writes back once in the DONE cycle.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   ex_mem_alu_result          : ALU result / memory address
//   ex_mem_store_data          : store data
//   ex_mem_rd_addr, ex_mem_wb  : destination register and RegWrite
//   ex_mem_m                   : [1]=MemRead, [0]=MemWrite (2'b11 is illegal)
//   dmem_req/we/addr/wdata     : registered memory request
//   dmem_rdata, dmem_ready     : memory response
//   mem_stall                  : combinational upstream hold
//   mem_wb_result/rd_addr/reg_write : writeback toward WB
//   bus_error                  : sticky, access timed out
//   illegal_op                 : sticky, M control was 2'b11
// ----------------------------------------------------------------------------
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     ex_mem_alu_result,
    input  logic [DATA_W-1:0]     ex_mem_store_data,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd_addr,
    input  logic [1:0]            ex_mem_m,
    input  logic                  ex_mem_wb,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  mem_stall,
    output logic [DATA_W-1:0]     mem_wb_result,
    output logic [REG_ADDR_W-1:0] mem_wb_rd_addr,
    output logic                  mem_wb_reg_write,
    output logic                  bus_error,
    output logic                  illegal_op
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_req;
    logic                r_we;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_is_load;
    logic                r_aborted;
    logic                r_bus_error;
    logic                r_illegal;

    logic                w_mem_op;
    logic                w_stall;
    logic [DATA_W-1:0]   w_result;
    logic                w_reg_write;

    assign w_mem_op = |ex_mem_m;

    always_comb begin
        w_stall = 1'b0;
        if (r_state == ACCESS)
            w_stall = 1'b1;
        else if (r_state == IDLE && w_mem_op)
            w_stall = 1'b1;
    end

    // Writeback selection is only consumed when not stalled, i.e. in DONE
    // (memory op finishing) or IDLE with a non-memory op.
    always_comb begin
        w_result    = ex_mem_alu_result;
        w_reg_write = ex_mem_wb;
        if (r_state == DONE) begin
            if (r_is_load)
                w_result = r_rdata;
            if (r_aborted)
                w_reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_is_load   <= 1'b0;
            r_aborted   <= 1'b0;
            r_bus_error <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_req     <= 1'b1;
                        // 2'b11 behaves as a load, so the write is suppressed
                        r_we      <= ex_mem_m[MEM_WRITE_BIT] & ~ex_mem_m[MEM_READ_BIT];
                        r_is_load <= ex_mem_m[MEM_READ_BIT];
                        r_addr    <= ex_mem_alu_result;
                        r_wdata   <= ex_mem_store_data;
                        r_cnt     <= '0;
                        r_aborted <= 1'b0;
                        if (&ex_mem_m)
                            r_illegal <= 1'b1;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        r_rdata <= dmem_rdata;
                        r_req   <= 1'b0;
                        r_state <= DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_req       <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_aborted   <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mem_wb_reg #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mem_wb_reg (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bubble    (w_stall),
        .i_result    (w_result),
        .i_rd_addr   (ex_mem_rd_addr),
        .i_reg_write (w_reg_write),
        .o_result    (mem_wb_result),
        .o_rd_addr   (mem_wb_rd_addr),
        .o_reg_write (mem_wb_reg_write)
    );

    assign mem_stall  = w_stall;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign bus_error  = r_bus_error;
    assign illegal_op = r_illegal;

endmodule
